jt49_div_multi: RTL and testbench

Multi-channel programmable clock-enable divider for the PSG tone and noise path. It is a parametrised successor to the single-channel square-wave divider. It provides `CH` independent channels of `W`-bit period, per-channel mode (toggle, pulse, one-shot, stop), and glitch-free period latching at cycle start. Each channel also has a synchronous restart and a terminal-count strobe. It sits between the register file and the tone/noise/envelope generators, driven by the core's divided clock enable.

---
 rtl/jt49_div_multi_if.sv | 24 ++
 rtl/jt49_div_multi.sv | 97 +++++++++
 tb/tb_jt49_div_multi.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/jt49_div_multi_if.sv
// Bus bundle for the multi-channel clock-enable divider: control inputs
// from the register file and the registered per-channel outputs.
interface jt49_div_multi_if #(
  parameter int W  = 12,
  parameter int CH = 3
);
  logic              cen;
  logic [CH*W-1:0]   period;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     restart;
  logic [CH-1:0]     div;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     busy;

  modport master (
    output cen, period, mode, restart,
    input  div, tick, busy
  );

  modport slave (
    input  cen, period, mode, restart,
    output div, tick, busy
  );
endinterface

// File: rtl/jt49_div_multi.sv
// CH independent programmable clock-enable dividers with toggle, pulse,
// one-shot and stop modes; the period is latched at each cycle start.
module jt49_div_multi #(
  parameter int W  = 12,
  parameter int CH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  jt49_div_multi_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_PULSE   = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_STOP    = 2'b11
  } mode_t;

  logic [W-1:0]  r_count [CH];
  logic [W-1:0]  r_act   [CH];
  logic [CH-1:0] r_div;
  logic [CH-1:0] r_tick;
  logic [CH-1:0] r_busy;

  mode_t         w_mode  [CH];
  logic [W-1:0]  w_per   [CH];
  logic [W-1:0]  w_eff   [CH];
  logic [CH-1:0] w_term;
  logic [CH-1:0] w_adv;

  // At cycle start (count==1) the live period is used so a fresh value
  // applies immediately; mid-cycle the latched copy keeps the cycle intact.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_mode[i] = mode_t'(bus.mode[2*i +: 2]);
      w_per[i]  = bus.period[i*W +: W];
      w_eff[i]  = (r_count[i] == W'(1)) ? w_per[i] : r_act[i];
      w_term[i] = (r_count[i] >= w_eff[i]);
      w_adv[i]  = bus.cen && ((w_mode[i] == MODE_TOGGLE) ||
                              (w_mode[i] == MODE_PULSE)  ||
                              ((w_mode[i] == MODE_ONESHOT) && r_busy[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_count[i] <= W'(1);
        r_act[i]   <= '0;
      end
      r_div  <= '0;
      r_tick <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (bus.restart[i]) begin
          r_count[i] <= W'(1);
          r_div[i]   <= 1'b0;
          r_tick[i]  <= 1'b0;
          r_busy[i]  <= (w_mode[i] == MODE_ONESHOT);
        end else begin
          r_tick[i] <= w_adv[i] && w_term[i];
          if (w_mode[i] != MODE_ONESHOT) begin
            r_busy[i] <= 1'b0;
          end
          if (w_adv[i]) begin
            if (r_count[i] == W'(1)) begin
              r_act[i] <= w_per[i];
            end
            r_count[i] <= w_term[i] ? W'(1) : r_count[i] + W'(1);
            case (w_mode[i])
              MODE_TOGGLE: begin
                if (w_term[i]) r_div[i] <= ~r_div[i];
              end
              MODE_PULSE: begin
                r_div[i] <= w_term[i];
              end
              MODE_ONESHOT: begin
                if (w_term[i]) begin
                  r_div[i]  <= 1'b1;
                  r_busy[i] <= 1'b0;
                end
              end
              default: begin
              end
            endcase
          end
        end
      end
    end
  end

  assign bus.div  = r_div;
  assign bus.tick = r_tick;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_jt49_div_multi.sv
// Randomized self-checking bench for jt49_div_multi against a per-channel
// behavioural model, plus directed one-shot, constant-cen and async-reset cases.
module tb_jt49_div_multi;
  localparam int W  = 12;
  localparam int CH = 3;

  logic clk;
  logic rst_n;

  jt49_div_multi_if #(.W(W), .CH(CH)) bus ();

  jt49_div_multi #(.W(W), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  int per [CH];
  int md  [CH];

  int mCount [CH];
  int mAct   [CH];
  bit mDiv   [CH];
  bit mTick  [CH];
  bit mBusy  [CH];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [CH-1:0] packBits(input bit b [CH]);
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = b[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      mCount[i] = 1;
      mAct[i]   = 0;
      mDiv[i]   = 0;
      mTick[i]  = 0;
      mBusy[i]  = 0;
    end
  endtask

  // One clock of the reference: each channel counts cens from 1 up to its
  // effective period, then acts according to its mode.
  task automatic modelStep(input bit cen, input logic [CH-1:0] rs);
    for (int i = 0; i < CH; i++) begin
      int  eff;
      bit  adv, term, nBusy;
      if (rs[i]) begin
        mCount[i] = 1;
        mDiv[i]   = 0;
        mTick[i]  = 0;
        mBusy[i]  = (md[i] == 2);
        continue;
      end
      adv   = cen && (md[i] < 2 || (md[i] == 2 && mBusy[i]));
      eff   = (mCount[i] == 1) ? per[i] : mAct[i];
      term  = (mCount[i] >= eff);
      nBusy = (md[i] == 2) ? mBusy[i] : 1'b0;
      if (adv) begin
        if (mCount[i] == 1) mAct[i] = per[i];
        mCount[i] = term ? 1 : mCount[i] + 1;
        if (md[i] == 0 && term) mDiv[i] = !mDiv[i];
        if (md[i] == 1) mDiv[i] = term;
        if (md[i] == 2 && term) begin
          mDiv[i] = 1;
          nBusy   = 0;
        end
      end
      mTick[i] = adv && term;
      mBusy[i] = nBusy;
    end
  endtask

  task automatic driveConfig();
    for (int i = 0; i < CH; i++) begin
      bus.period[i*W +: W] = W'(per[i]);
      bus.mode[2*i +: 2]   = 2'(md[i]);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".div"},  32'(bus.div),  32'(packBits(mDiv)));
    checkOutput({tag, ".tick"}, 32'(bus.tick), 32'(packBits(mTick)));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(packBits(mBusy)));
  endtask

  task automatic applyStimulus(input bit cen, input logic [CH-1:0] rs, input string tag);
    driveConfig();
    bus.cen     = cen;
    bus.restart = rs;
    @(posedge clk);
    modelStep(cen, rs);
    #1;
    compareAll(tag);
  endtask

  initial begin
    int riseAt;
    rst_n       = 1'b0;
    bus.cen     = 1'b0;
    bus.restart = '0;
    for (int i = 0; i < CH; i++) begin
      per[i] = 0;
      md[i]  = 0;
    end
    driveConfig();
    modelReset();
    #12;
    compareAll("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Toggle mode, cen every 2nd clk, periods 3/5/7.
    per[0] = 3; per[1] = 5; per[2] = 7;
    for (int k = 0; k < 60; k++) applyStimulus(k[0], '0, "toggle");

    // Constant cen with period 0 and 1: tick every clk.
    per[0] = 0; per[1] = 1; per[2] = 0;
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, '0, "p01");
    checkOutput("tickConst", 32'(bus.tick), 32'h7);

    // One-shot, P=5: idle, then restart and wait for the rise.
    for (int i = 0; i < CH; i++) begin
      md[i]  = 2;
      per[i] = 5;
    end
    applyStimulus(1'b1, 3'b111, "osInit");
    applyStimulus(1'b1, '0, "osInit");
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, '0, "osIdle");
    applyStimulus(1'b1, 3'b001, "osStart");
    riseAt = -1;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, '0, "osRun");
      if (riseAt < 0 && bus.div[0]) riseAt = k;
    end
    checkOutput("osRiseCen", 32'(riseAt), 32'd5);

    // Randomized mix of modes, periods, restarts and cen patterns.
    for (int i = 0; i < CH; i++) md[i] = 0;
    for (int k = 0; k < 800; k++) begin
      logic [CH-1:0] rs;
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 9) == 0)  per[i] = $urandom_range(0, 9);
        if ($urandom_range(0, 39) == 0) md[i]  = $urandom_range(0, 3);
        rs[i] = ($urandom_range(0, 15) == 0);
      end
      applyStimulus($urandom_range(0, 2) != 0, rs, "rand");
    end

    // Async reset between clock edges with active outputs.
    for (int i = 0; i < CH; i++) begin
      md[i]  = 0;
      per[i] = 0;
    end
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, '0, "preRst");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll("asyncRst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, '0, "postRst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
